// File: rtl/tron_pkg.sv
// Shared encodings and helpers for the tron step engine.
package tron_pkg;

  // One-hot direction request encoding {up, down, left, right}.
  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int unsigned ADDR_W = $clog2(160 * 120);

  typedef enum logic [3:0] {
    StIdle, StClear, StInit1, StInit2, StWaitTick, StMove,
    StRead1, StCheck1, StRead2, StCheck2, StWrite1, StWrite2, StOver
  } state_e;

  // Reverse swaps up<->down and left<->right.
  function automatic logic [3:0] dir_reverse(logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  // Accept a request only if it is a single direction and not a U-turn.
  function automatic logic [3:0] dir_update(logic [3:0] cur, logic [3:0] req);
    if ($onehot(req) && (req != dir_reverse(cur))) return req;
    return cur;
  endfunction

endpackage

// File: rtl/occupancy_ram.sv
// Single-port 1-bit-per-pixel occupancy memory, one-cycle read latency.
module occupancy_ram import tron_pkg::*; #(
  parameter int unsigned Depth = 160 * 120,
  parameter int unsigned AddrW = ADDR_W
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic             wdata_i,
  output logic             rdata_o
);

  logic mem_q [Depth];
  logic rdata_q;

  // Synchronous write and registered read on the shared address.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tron_step_engine.sv
// Game-tick engine: moves both light cycles, detects crashes, emits pixel plots.
module tron_step_engine import tron_pkg::*; #(
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120,
  parameter int unsigned TICK_DIV  = 2000000,
  parameter int unsigned P1_X0     = 8,
  parameter int unsigned P1_Y0     = 8,
  parameter int unsigned P2_X0     = 151,
  parameter int unsigned P2_Y0     = 111,
  parameter logic [2:0]  P1_COLOUR = 3'b101,
  parameter logic [2:0]  P2_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] p1_dir,
  input  logic [3:0] p2_dir,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned Depth = SCREEN_W * SCREEN_H;
  localparam int unsigned AW    = $clog2(Depth);

  state_e      state_q, state_d;
  logic [31:0] tick_q, tick_d;
  logic [7:0]  clr_x_q, clr_x_d, p1_x_q, p1_x_d, p2_x_q, p2_x_d, n1_x_q, n1_x_d, n2_x_q, n2_x_d;
  logic [6:0]  clr_y_q, clr_y_d, p1_y_q, p1_y_d, p2_y_q, p2_y_d, n1_y_q, n1_y_d, n2_y_q, n2_y_d;
  logic [3:0]  p1_hd_q, p1_hd_d, p2_hd_q, p2_hd_d;
  logic        bord1_q, bord1_d, bord2_q, bord2_d, crash1_q, crash1_d;
  logic [1:0]  winner_q, winner_d;

  logic          ram_we, ram_re, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  // Next-position arithmetic carries one extra bit; a step below zero wraps to a
  // large value, so a single unsigned >= test catches both borders.
  logic [3:0] p1_hd_new, p2_hd_new;
  logic [8:0] n1_x, n2_x;
  logic [7:0] n1_y, n2_y;
  logic       n1_border, n2_border, head_on, crash1_now, crash2_now;

  function automatic logic [AW-1:0] pix_addr(logic [7:0] px, logic [6:0] py);
    return AW'(py) * AW'(SCREEN_W) + AW'(px);
  endfunction

  function automatic logic [8:0] step_x(logic [7:0] px, logic [3:0] d);
    if (d == DIR_RIGHT) return {1'b0, px} + 9'd1;
    if (d == DIR_LEFT)  return {1'b0, px} - 9'd1;
    return {1'b0, px};
  endfunction

  function automatic logic [7:0] step_y(logic [6:0] py, logic [3:0] d);
    if (d == DIR_DOWN) return {1'b0, py} + 8'd1;
    if (d == DIR_UP)   return {1'b0, py} - 8'd1;
    return {1'b0, py};
  endfunction

  assign p1_hd_new  = dir_update(p1_hd_q, p1_dir);
  assign p2_hd_new  = dir_update(p2_hd_q, p2_dir);
  assign n1_x       = step_x(p1_x_q, p1_hd_new);
  assign n1_y       = step_y(p1_y_q, p1_hd_new);
  assign n2_x       = step_x(p2_x_q, p2_hd_new);
  assign n2_y       = step_y(p2_y_q, p2_hd_new);
  assign n1_border  = (n1_x >= 9'(SCREEN_W)) || (n1_y >= 8'(SCREEN_H));
  assign n2_border  = (n2_x >= 9'(SCREEN_W)) || (n2_y >= 8'(SCREEN_H));
  assign head_on    = !bord1_q && !bord2_q && (n1_x_q == n2_x_q) && (n1_y_q == n2_y_q);
  assign crash1_now = crash1_q || head_on;
  assign crash2_now = bord2_q || ram_rdata || head_on;

  // Next-state, RAM control and plot outputs.
  always_comb begin
    state_d = state_q;   tick_d = tick_q;
    clr_x_d = clr_x_q;   clr_y_d = clr_y_q;
    p1_x_d = p1_x_q;     p1_y_d = p1_y_q;     p2_x_d = p2_x_q;     p2_y_d = p2_y_q;
    n1_x_d = n1_x_q;     n1_y_d = n1_y_q;     n2_x_d = n2_x_q;     n2_y_d = n2_y_q;
    p1_hd_d = p1_hd_q;   p2_hd_d = p2_hd_q;
    bord1_d = bord1_q;   bord2_d = bord2_q;   crash1_d = crash1_q; winner_d = winner_q;
    ram_we = 1'b0; ram_re = 1'b0; ram_wdata = 1'b0; ram_addr = '0;
    x = '0; y = '0; colour = '0; plot = 1'b0;
    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d  = StClear;
          clr_x_d  = '0;
          clr_y_d  = '0;
          winner_d = WIN_NONE;
        end
      end
      StClear: begin
        plot = 1'b1; x = clr_x_q; y = clr_y_q;
        ram_we = 1'b1; ram_addr = pix_addr(clr_x_q, clr_y_q);
        if (clr_x_q == 8'(SCREEN_W - 1)) begin
          clr_x_d = '0;
          if (clr_y_q == 7'(SCREEN_H - 1)) state_d = StInit1;
          else clr_y_d = clr_y_q + 7'd1;
        end else begin
          clr_x_d = clr_x_q + 8'd1;
        end
      end
      StInit1: begin
        p1_x_d = 8'(P1_X0); p1_y_d = 7'(P1_Y0); p1_hd_d = DIR_RIGHT;
        plot = 1'b1; x = 8'(P1_X0); y = 7'(P1_Y0); colour = P1_COLOUR;
        ram_we = 1'b1; ram_wdata = 1'b1; ram_addr = pix_addr(8'(P1_X0), 7'(P1_Y0));
        state_d = StInit2;
      end
      StInit2: begin
        p2_x_d = 8'(P2_X0); p2_y_d = 7'(P2_Y0); p2_hd_d = DIR_LEFT;
        plot = 1'b1; x = 8'(P2_X0); y = 7'(P2_Y0); colour = P2_COLOUR;
        ram_we = 1'b1; ram_wdata = 1'b1; ram_addr = pix_addr(8'(P2_X0), 7'(P2_Y0));
        state_d = StWaitTick;
      end
      StWaitTick: begin
        if (tick_q == 32'(TICK_DIV - 1)) begin
          tick_d  = '0;
          state_d = StMove;
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
      StMove: begin
        p1_hd_d = p1_hd_new; n1_x_d = n1_x[7:0]; n1_y_d = n1_y[6:0]; bord1_d = n1_border;
        p2_hd_d = p2_hd_new; n2_x_d = n2_x[7:0]; n2_y_d = n2_y[6:0]; bord2_d = n2_border;
        state_d = StRead1;
      end
      StRead1: begin
        // An off-screen target has no RAM address; its crash is already known.
        ram_re   = !bord1_q;
        ram_addr = bord1_q ? '0 : pix_addr(n1_x_q, n1_y_q);
        state_d  = StCheck1;
      end
      StCheck1: begin
        crash1_d = bord1_q || ram_rdata;
        state_d  = StRead2;
      end
      StRead2: begin
        ram_re   = !bord2_q;
        ram_addr = bord2_q ? '0 : pix_addr(n2_x_q, n2_y_q);
        state_d  = StCheck2;
      end
      StCheck2: begin
        if (crash1_now || crash2_now) begin
          state_d = StOver;
          if (crash1_now && crash2_now) winner_d = WIN_DRAW;
          else if (crash1_now)          winner_d = WIN_P2;
          else                          winner_d = WIN_P1;
        end else begin
          state_d = StWrite1;
        end
      end
      StWrite1: begin
        p1_x_d = n1_x_q; p1_y_d = n1_y_q;
        plot = 1'b1; x = n1_x_q; y = n1_y_q; colour = P1_COLOUR;
        ram_we = 1'b1; ram_wdata = 1'b1; ram_addr = pix_addr(n1_x_q, n1_y_q);
        state_d = StWrite2;
      end
      StWrite2: begin
        p2_x_d = n2_x_q; p2_y_d = n2_y_q;
        plot = 1'b1; x = n2_x_q; y = n2_y_q; colour = P2_COLOUR;
        ram_we = 1'b1; ram_wdata = 1'b1; ram_addr = pix_addr(n2_x_q, n2_y_q);
        state_d = StWaitTick;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy      = (state_q != StIdle) && (state_q != StOver);
  assign game_over = (state_q == StOver);
  assign winner    = winner_q;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;  tick_q <= '0;
      clr_x_q <= '0;      clr_y_q <= '0;
      p1_x_q <= '0;       p1_y_q <= '0;       p2_x_q <= '0;       p2_y_q <= '0;
      n1_x_q <= '0;       n1_y_q <= '0;       n2_x_q <= '0;       n2_y_q <= '0;
      p1_hd_q <= '0;      p2_hd_q <= '0;
      bord1_q <= 1'b0;    bord2_q <= 1'b0;    crash1_q <= 1'b0;   winner_q <= '0;
    end else begin
      state_q <= state_d; tick_q <= tick_d;
      clr_x_q <= clr_x_d; clr_y_q <= clr_y_d;
      p1_x_q <= p1_x_d;   p1_y_q <= p1_y_d;   p2_x_q <= p2_x_d;   p2_y_q <= p2_y_d;
      n1_x_q <= n1_x_d;   n1_y_q <= n1_y_d;   n2_x_q <= n2_x_d;   n2_y_q <= n2_y_d;
      p1_hd_q <= p1_hd_d; p2_hd_q <= p2_hd_d;
      bord1_q <= bord1_d; bord2_q <= bord2_d; crash1_q <= crash1_d; winner_q <= winner_d;
    end
  end

  occupancy_ram #(
    .Depth (Depth),
    .AddrW (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_tron_step_engine.sv
// Bench: game-level model of the tron engine producing a per-cycle expected output stream.
module tb_tron_step_engine;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int TD = 4;
  localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, LT = 4'b0010, RT = 4'b0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [3:0] p1_dir = 4'b0, p2_dir = 4'b0;
  logic [7:0] x_a, x_b;
  logic [6:0] y_a, y_b;
  logic [2:0] colour_a, colour_b;
  logic       plot_a, plot_b, busy_a, busy_b, go_a, go_b;
  logic [1:0] win_a, win_b;

  always #5 clk = ~clk;

  tron_step_engine #(
    .SCREEN_W (16), .SCREEN_H (8), .TICK_DIV (4),
    .P1_X0 (1), .P1_Y0 (1), .P2_X0 (14), .P2_Y0 (6)
  ) dut_a (
    .clk (clk), .reset (reset), .start (start_a), .p1_dir (p1_dir), .p2_dir (p2_dir),
    .x (x_a), .y (y_a), .colour (colour_a), .plot (plot_a), .busy (busy_a),
    .game_over (go_a), .winner (win_a)
  );

  tron_step_engine #(
    .SCREEN_W (16), .SCREEN_H (8), .TICK_DIV (4),
    .P1_X0 (1), .P1_Y0 (1), .P2_X0 (5), .P2_Y0 (1)
  ) dut_b (
    .clk (clk), .reset (reset), .start (start_b), .p1_dir (p1_dir), .p2_dir (p2_dir),
    .x (x_b), .y (y_b), .colour (colour_b), .plot (plot_b), .busy (busy_b),
    .game_over (go_b), .winner (win_b)
  );

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic       busy;
    logic       go;
    logic [1:0] win;
  } obs_t;

  obs_t expq[$];
  obs_t steady[2];
  obs_t exp_o, act_o;
  bit   chk_en = 1'b0;
  bit   sel_b = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // Game model: occupancy grid, heads and headings.
  bit         occ[W][H];
  int         hx[2], hy[2];
  logic [3:0] hd[2];
  logic [1:0] last_win;
  bit         over;

  function automatic obs_t mk(logic p, int xx, int yy, logic [2:0] c, logic b, logic g,
                              logic [1:0] w);
    obs_t e;
    e.plot = p; e.x = 8'(xx); e.y = 7'(yy); e.col = c; e.busy = b; e.go = g; e.win = w;
    return e;
  endfunction

  function automatic logic [3:0] opposite(logic [3:0] d);
    case (d)
      UP:      return DN;
      DN:      return UP;
      LT:      return RT;
      default: return LT;
    endcase
  endfunction

  function automatic logic [3:0] rand_dir();
    if ($urandom_range(0, 3) != 0) return 4'b0001 << $urandom_range(0, 3);
    return 4'($urandom_range(0, 15));
  endfunction

  // One expected entry per cycle; x/y/colour only matter while plotting.
  always @(negedge clk) begin
    if (chk_en) begin
      if (expq.size() > 0) exp_o = expq.pop_front();
      else exp_o = steady[sel_b];
      if (sel_b) act_o = {plot_b, x_b, y_b, colour_b, busy_b, go_b, win_b};
      else       act_o = {plot_a, x_a, y_a, colour_a, busy_a, go_a, win_a};
      vectors++;
      if (act_o.plot !== exp_o.plot || act_o.busy !== exp_o.busy || act_o.go !== exp_o.go ||
          act_o.win !== exp_o.win ||
          (exp_o.plot && (act_o.x !== exp_o.x || act_o.y !== exp_o.y ||
                          act_o.col !== exp_o.col))) begin
        miscompares++;
        $display("FAIL cycle t=%0t dut=%s got plot=%b x=%0d y=%0d col=%b busy=%b go=%b win=%b ; want plot=%b x=%0d y=%0d col=%b busy=%b go=%b win=%b",
                 $time, sel_b ? "b" : "a", act_o.plot, act_o.x, act_o.y, act_o.col, act_o.busy,
                 act_o.go, act_o.win, exp_o.plot, exp_o.x, exp_o.y, exp_o.col, exp_o.busy,
                 exp_o.go, exp_o.win);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // Pulse start and queue the full clear sweep plus both head plots (130 cycles).
  task automatic begin_game(input bit b, input int p2x, input int p2y);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        occ[xx][yy] = 1'b0;
        expq.push_back(mk(1, xx, yy, 3'b000, 1, 0, 2'b00));
      end
    end
    hx[0] = 1;   hy[0] = 1;   hd[0] = RT;
    hx[1] = p2x; hy[1] = p2y; hd[1] = LT;
    occ[1][1] = 1'b1;
    occ[p2x][p2y] = 1'b1;
    expq.push_back(mk(1, 1, 1, 3'b101, 1, 0, 2'b00));
    expq.push_back(mk(1, p2x, p2y, 3'b010, 1, 0, 2'b00));
    steady[b] = mk(0, 0, 0, 3'b000, 1, 0, 2'b00);
  endtask

  // One game tick from the start of the wait period: apply requests, predict, advance.
  task automatic tick(input logic [3:0] r1, input logic [3:0] r2, output bit ov);
    int         nx[2], ny[2];
    bit         oob[2], cr[2];
    logic [3:0] req[2];
    p1_dir = r1;
    p2_dir = r2;
    req[0] = r1;
    req[1] = r2;
    for (int i = 0; i < 2; i++) begin
      if ($countones(req[i]) == 1 && req[i] != opposite(hd[i])) hd[i] = req[i];
      nx[i] = hx[i];
      ny[i] = hy[i];
      case (hd[i])
        UP:      ny[i] = ny[i] - 1;
        DN:      ny[i] = ny[i] + 1;
        LT:      nx[i] = nx[i] - 1;
        default: nx[i] = nx[i] + 1;
      endcase
      oob[i] = nx[i] < 0 || nx[i] >= W || ny[i] < 0 || ny[i] >= H;
      cr[i]  = oob[i] ? 1'b1 : occ[nx[i]][ny[i]];
    end
    if (nx[0] == nx[1] && ny[0] == ny[1]) begin
      cr[0] = 1'b1;
      cr[1] = 1'b1;
    end
    for (int k = 0; k < TD + 5; k++) expq.push_back(mk(0, 0, 0, 3'b000, 1, 0, 2'b00));
    if (cr[0] || cr[1]) begin
      last_win = {cr[0], cr[1]};
      steady[sel_b] = mk(0, 0, 0, 3'b000, 0, 1, last_win);
      ov = 1'b1;
      run(TD + 5);
    end else begin
      for (int i = 0; i < 2; i++) begin
        hx[i] = nx[i];
        hy[i] = ny[i];
        occ[nx[i]][ny[i]] = 1'b1;
      end
      expq.push_back(mk(1, hx[0], hy[0], 3'b101, 1, 0, 2'b00));
      expq.push_back(mk(1, hx[1], hy[1], 3'b010, 1, 0, 2'b00));
      ov = 1'b0;
      run(TD + 7);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    expq.delete();
    steady[0] = mk(0, 0, 0, 3'b000, 0, 0, 2'b00);
    steady[1] = mk(0, 0, 0, 3'b000, 0, 0, 2'b00);
  endtask

  initial begin
    steady[0] = mk(0, 0, 0, 3'b000, 0, 0, 2'b00);
    steady[1] = mk(0, 0, 0, 3'b000, 0, 0, 2'b00);
    run(3);
    chk_en = 1'b1;
    run(2);
    reset = 1'b0;
    run(3);
    pin("reset_busy", busy_a, 0);
    pin("reset_game_over", go_a, 0);

    // Clear sweep and head initialisation.
    sel_b = 1'b0;
    begin_game(1'b0, 14, 6);
    run(130);
    pin("init_busy", busy_a, 1);

    // Straight-line tick.
    tick(4'b0000, 4'b0000, over);
    pin("t1_p1x", hx[0], 2);
    pin("t1_p2x", hx[1], 13);
    pin("t1_p2y", hy[1], 6);

    // Reverse and multi-bit requests are ignored.
    tick(LT, 4'b0101, over);
    pin("t2_p1x", hx[0], 3);
    pin("t2_p2x", hx[1], 12);

    // Up twice into the top border ends this game.
    tick(UP, 4'b0000, over);
    pin("t3_p1y", hy[0], 0);
    tick(UP, 4'b0000, over);
    pin("top_border_over", over, 1);
    pin("top_border_win", win_a, 2'b10);
    pin("top_border_busy", busy_a, 0);

    // Restart from OVER; up from the start position.
    begin_game(1'b0, 14, 6);
    run(130);
    tick(UP, 4'b0000, over);
    pin("s4_p1y", hy[0], 0);
    tick(UP, 4'b0000, over);
    pin("s4_win", last_win, 2'b10);

    // Head-on on the second instance.
    sel_b = 1'b1;
    p1_dir = 4'b0000;
    p2_dir = 4'b0000;
    begin_game(1'b1, 5, 1);
    run(130);
    tick(4'b0000, 4'b0000, over);
    pin("ho_p1x", hx[0], 2);
    pin("ho_p2x", hx[1], 4);
    tick(4'b0000, 4'b0000, over);
    pin("ho_win_model", last_win, 2'b11);
    pin("ho_win_dut", win_b, 2'b11);

    // Loop into own trail.
    sel_b = 1'b0;
    begin_game(1'b0, 14, 6);
    run(130);
    tick(RT, 4'b0000, over);
    tick(DN, 4'b0000, over);
    tick(LT, 4'b0000, over);
    tick(UP, 4'b0000, over);
    pin("loop_win", last_win, 2'b10);

    // Reset during a clear sweep, then a fresh full game start.
    begin_game(1'b0, 14, 6);
    run(40);
    do_reset();
    pin("abort_plot", plot_a, 0);
    pin("abort_busy", busy_a, 0);
    run(2);
    begin_game(1'b0, 14, 6);
    run(130);

    // Randomized games; an unfinished game is aborted through reset.
    for (int g = 0; g < 8; g++) begin
      over = 1'b0;
      for (int t = 0; t < 40 && !over; t++) tick(rand_dir(), rand_dir(), over);
      if (!over) begin
        do_reset();
        run(2);
      end
      begin_game(1'b0, 14, 6);
      run(130);
    end
    do_reset();
    run(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tron_step_engine.md
Name: tron_step_engine

Overview:
Game-tick engine between the player switches and the vga_adapter.
- Holds both light-cycle heads and their directions.
- Advances each head one pixel per game tick.
- Detects border, trail and head-on collisions against a 1-bit-per-pixel occupancy RAM.
- Issues single-pixel plot requests (x, y, colour, plot) that go straight to the vga_adapter.
- Its CLEAR sweep also wipes the screen at game start.

Parameters:
- SCREEN_W, 160, playfield width in pixels
- SCREEN_H, 120, playfield height in pixels
- TICK_DIV, 2000000, clk cycles per game tick
- P1_X0, 8, player 1 start x
- P1_Y0, 8, player 1 start y
- P2_X0, 151, player 2 start x
- P2_Y0, 111, player 2 start y
- P1_COLOUR, 3'b101, player 1 trail colour
- P2_COLOUR, 3'b010, player 2 trail colour

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level/pulse; begins a game when in IDLE or OVER
- p1_dir  in  4  player 1 request, one-hot {up,down,left,right}
- p2_dir  in  4  player 2 request, same encoding
- x  out  8  plot x
- y  out  7  plot y
- colour  out  3  plot colour
- plot  out  1  one-cycle pixel write strobe
- busy  out  1  game in progress (CLEAR through WRITE2)
- game_over  out  1  high in OVER
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw; valid while game_over=1

Behaviour:
Reset:
- All outputs are 0; state goes to IDLE.
- Tick counter is 0.
- Reset mid-game aborts immediately; RAM contents are then undefined, so every start goes through CLEAR.

States: IDLE, CLEAR, INIT1, INIT2, WAIT_TICK, MOVE, READ1, CHECK1, READ2, CHECK2, WRITE1, WRITE2, OVER.

State transitions and actions:
- IDLE/OVER: if start=1, go to CLEAR, set game_over=0 and winner=00. Otherwise start is ignored in every other state.
- CLEAR:
  - Sweeps addr = y*SCREEN_W + x in raster order, one pixel per cycle.
  - Writes RAM bit 0 and plots colour 000 each cycle.
  - Total SCREEN_W*SCREEN_H cycles, then go to INIT1.
- INIT1/INIT2:
  - Load heads to the start positions; directions are P1=right, P2=left.
  - Set RAM bit and plot each head in its colour, one per state.
  - Then go to WAIT_TICK.
- WAIT_TICK:
  - Counter runs 0..TICK_DIV-1.
  - At terminal count: reset the counter and go to MOVE.
- MOVE:
  - Sample p*_dir. A request is accepted only if exactly one bit is set and it is not the reverse of the current direction; otherwise the direction is held.
  - Compute next positions with one-bit-wider signed arithmetic.
  - Border crash if next x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H.
- READ1/READ2: issue a synchronous RAM read for P1/P2 next address. Read latency is 1 cycle, so data is used in CHECK1/CHECK2.
- CHECK1/CHECK2:
  - A player crashes if it has a border crash or its occupancy bit is 1. A border-crashed player skips its read (crash already set).
  - If both next positions are equal, both crash (head-on).
  - Swaps are caught by the occupancy check, because current heads are already in the RAM.
- After CHECK2:
  - If any crash: go to OVER. winner = 01 if only P2 crashed, 10 if only P1 crashed, 11 if both crashed. No plot is issued.
  - Else go to WRITE1.
- WRITE1/WRITE2: commit the head, set the RAM bit, plot one pixel in the player colour, then go to WAIT_TICK.

Output rules:
- plot is high only in CLEAR, INIT1/2 and WRITE1/2.
- x, y and colour are valid in the same cycle as plot.
- busy=1 in all states except IDLE and OVER.

Latency:
- start to first CLEAR plot: 1 cycle.
- Game tick to P1 plot: 6 cycles (MOVE, READ1, CHECK1, READ2, CHECK2, WRITE1).

Decomposition:
- tron_pkg holds:
  - direction encodings DIR_UP/DOWN/LEFT/RIGHT
  - winner codes
  - state enum
  - ADDR_W = clog2(SCREEN_W*SCREEN_H) (15 at default size)
- Sub-module occupancy_ram:
  - single port, SCREEN_W*SCREEN_H x 1
  - synchronous write, synchronous read with 1-cycle latency

Test Plan:
Bench overrides: SCREEN_W=16, SCREEN_H=8, TICK_DIV=4, P1=(1,1), P2=(14,6).
1. reset, then start=1 for 1 cycle -> 128 plot pulses at colour 000 in raster order; then (1,1) at 101 and (14,6) at 010; busy=1, game_over=0.
2. No direction input, one tick -> plot (2,1) colour 101, then (13,6) colour 010, on consecutive cycles.
3. p1_dir=0010 (left) while moving right, and p2_dir=0101 (multi-bit) -> both requests ignored; next tick plots (3,1) and (12,6).
4. p1_dir=1000 (up) from (1,1) -> tick 1 plots (1,0); tick 2 gives game_over=1, winner=10, no further plot, busy=0.
5. Override P2=(5,1) -> after tick 1 heads are at (2,1)/(4,1); tick 2 targets (3,1) for both -> winner=11.
6. P1 loops right, down, left, up into its own trail -> winner=10. Then assert reset mid-CLEAR of a restarted game -> all outputs 0 next cycle, state IDLE; a fresh start completes the full 128-pixel clear.
